// File: rtl/tl_fc_pending_buffer_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tl_fc_pending_buffer_mc                                       |
// | Brief    : Per-channel TLP pending FIFOs with FC credit gating and a     |
// |            round-robin arbiter feeding one registered valid/ready stage. |
// |            Optional macro TL_FC_INFINITE_CREDIT_EN: cr_limit==0 means    |
// |            infinite credit for that channel.                             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tl_fc_pending_buffer_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CH     = 3,
    parameter int CR_WIDTH   = 8,
    parameter int COST_WIDTH = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        wr_valid,
    output logic                                        wr_ready,
    input  logic [$clog2(NUM_CH)-1:0]                   wr_ch,
    input  logic [DATA_WIDTH-1:0]                       wr_data,
    input  logic [COST_WIDTH-1:0]                       wr_cost,
    input  logic [NUM_CH*CR_WIDTH-1:0]                  cr_limit,
    output logic                                        tx_valid,
    input  logic                                        tx_ready,
    output logic [DATA_WIDTH-1:0]                       tx_data,
    output logic [$clog2(NUM_CH)-1:0]                   tx_ch,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    ptlp,
    output logic [NUM_CH*CR_WIDTH-1:0]                  credit_consumed,
    output logic [NUM_CH-1:0]                           full,
    output logic [NUM_CH-1:0]                           empty
);

    localparam int CHW  = $clog2(NUM_CH);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int EW   = COST_WIDTH + DATA_WIDTH;
    localparam logic [CR_WIDTH-1:0] HALF = CR_WIDTH'(1 << (CR_WIDTH - 1));

    logic [EW-1:0]         mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr [NUM_CH];
    logic [AW-1:0]         rd_ptr [NUM_CH];
    logic [PW-1:0]         cnt [NUM_CH];
    logic [CR_WIDTH-1:0]   cc [NUM_CH];
    logic [DATA_WIDTH-1:0] head_data [NUM_CH];
    logic [COST_WIDTH-1:0] head_cost [NUM_CH];
    logic [NUM_CH-1:0]     elig;
    logic [NUM_CH-1:0]     wr_hit;
    logic [NUM_CH-1:0]     pop_hit;
    logic [CHW-1:0]        rr_ptr;
    logic [CHW-1:0]        grant;
    logic                  grant_vld;
    logic                  load;
    logic                  wr_ok;
    logic                  do_pop;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CR_WIDTH-1:0] limit;
            logic [CR_WIDTH-1:0] diff;

            assign limit     = cr_limit[i*CR_WIDTH +: CR_WIDTH];
            assign head_data[i] = mem[i][rd_ptr[i]][DATA_WIDTH-1:0];
            assign head_cost[i] = mem[i][rd_ptr[i]][EW-1 -: COST_WIDTH];
            // Remaining headroom after this TLP; values above half the range mean "negative".
            assign diff      = limit - cc[i] - CR_WIDTH'(head_cost[i]);
            assign full[i]   = (cnt[i] == PW'(FIFO_DEPTH));
            assign empty[i]  = (cnt[i] == '0);
            assign ptlp[i*PW +: PW]                 = cnt[i];
            assign credit_consumed[i*CR_WIDTH +: CR_WIDTH] = cc[i];
            assign wr_hit[i]  = wr_ok && (wr_ch == CHW'(i));
            assign pop_hit[i] = do_pop && (grant == CHW'(i));
`ifdef TL_FC_INFINITE_CREDIT_EN
            assign elig[i] = !empty[i] && ((limit == '0) || (diff <= HALF));
`else
            assign elig[i] = !empty[i] && (diff <= HALF);
`endif
        end
    endgenerate

    always_comb begin
        wr_ready = 1'b0;
        if (int'(wr_ch) < NUM_CH) begin
            wr_ready = !full[wr_ch];
        end
    end

    assign wr_ok  = wr_valid && wr_ready;
    assign load   = !tx_valid || tx_ready;
    assign do_pop = load && grant_vld;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant     = CHW'(idx);
            end
        end
    end

    // Storage is not reset; occupancy counters alone define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_hit[i]) begin
                mem[i][wr_ptr[i]] <= {wr_cost, wr_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
                cc[i]     <= '0;
            end
            rr_ptr   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_ch    <= '0;
        end else begin
            if (load) begin
                if (grant_vld) begin
                    tx_valid <= 1'b1;
                    tx_data  <= head_data[grant];
                    tx_ch    <= grant;
                    rr_ptr   <= (grant == CHW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                end else begin
                    tx_valid <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop_hit[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    cc[i]     <= cc[i] + CR_WIDTH'(head_cost[i]);
                end
                cnt[i] <= cnt[i] + PW'(wr_hit[i]) - PW'(pop_hit[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_fc_pending_buffer_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tl_fc_pending_buffer_mc                                    |
// | Brief    : Directed scoreboard bench for tl_fc_pending_buffer_mc.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_tl_fc_pending_buffer_mc;

    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int CRW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic            wr_ready;
    logic [1:0]      wr_ch;
    logic [DW-1:0]   wr_data;
    logic [3:0]      wr_cost;
    logic [NCH*CRW-1:0] cr_limit;
    logic            tx_valid;
    logic            tx_ready;
    logic [DW-1:0]   tx_data;
    logic [1:0]      tx_ch;
    logic [14:0]     ptlp;
    logic [NCH*CRW-1:0] credit_consumed;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  empty;

    int total = 0;
    int bad   = 0;
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] exp_e;

    tl_fc_pending_buffer_mc dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
        .wr_data(wr_data), .wr_cost(wr_cost), .cr_limit(cr_limit),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_ch(tx_ch),
        .ptlp(ptlp), .credit_consumed(credit_consumed), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Monitor: every handshake must match the oldest expected TLP.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected actual ch=%0d data=%h required=none", tx_ch, tx_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({tx_ch, tx_data} !== exp_e) begin
                    bad++;
                    $display("FAIL tx_order actual ch=%0d data=%h required ch=%0d data=%h",
                             tx_ch, tx_data, exp_e[DW+1:DW], exp_e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] d, input int cost, input bit expect_out);
        wr_valid = 1'b1;
        wr_ch    = 2'(ch);
        wr_data  = d;
        wr_cost  = 4'(cost);
        if (expect_out) exp_q.push_back({2'(ch), d});
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic set_lim(input int ch, input int v);
        cr_limit[ch*CRW +: CRW] = 8'(v);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (exp_q.size() == 0 && !tx_valid) done = 1'b1;
            else tick();
        end
        chk(name, 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_data = '0; wr_cost = '0;
        cr_limit = '0; tx_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'h7);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_ptlp", 64'(ptlp), 64'h0);
        chk("rst_cc", 64'(credit_consumed), 64'h0);

        // Fill ch0 while its limit of zero blocks every issue.
        for (int k = 0; k < 16; k++) wr(0, 32'hA000_0000 + k, 1, 1'b1);
        wr_ch = 2'd0;
        #1;
        chk("fill_full", 64'(full), 64'h1);
        chk("fill_wr_ready", 64'(wr_ready), 64'd0);
        chk("fill_ptlp0", 64'(ptlp[4:0]), 64'd16);
        chk("fill_tx_valid", 64'(tx_valid), 64'd0);
        wr(0, 32'hDEAD_BEEF, 1, 1'b0);
        chk("overflow_ptlp0", 64'(ptlp[4:0]), 64'd16);

        set_lim(0, 5);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_cc0", 64'(credit_consumed[7:0]), 64'd5);
        chk("stall_ptlp0", 64'(ptlp[4:0]), 64'd11);
        chk("stall_tx_valid", 64'(tx_valid), 64'd0);
        chk("stall_pending", 64'(exp_q.size()), 64'd11);
        set_lim(0, 16);
        wait_drain("drain_ch0");
        chk("drain_cc0", 64'(credit_consumed[7:0]), 64'd16);
        chk("drain_ptlp0", 64'(ptlp[4:0]), 64'd0);

        // Round robin across all channels, with an output hold in the middle.
        rst = 1'b1; tick(); rst = 1'b0;
        set_lim(0, 100); set_lim(1, 100); set_lim(2, 100);
        tx_ready = 1'b0;
        wr(0, 32'hC000_0000, 1, 1'b0);
        chk("latency_n", 64'(tx_valid), 64'd0);
        wr(0, 32'hC000_0001, 1, 1'b0);
        chk("latency_n1", 64'(tx_valid), 64'd1);
        wr(1, 32'hC000_0010, 1, 1'b0);
        wr(1, 32'hC000_0011, 1, 1'b0);
        wr(2, 32'hC000_0020, 1, 1'b0);
        wr(2, 32'hC000_0021, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_data", 64'(tx_data), 64'hC000_0000);
            chk("hold_ch", 64'(tx_ch), 64'd0);
            chk("hold_ptlp", 64'(ptlp), 64'({5'd2, 5'd2, 5'd1}));
            tick();
        end
        exp_q.push_back({2'd0, 32'hC000_0000});
        exp_q.push_back({2'd1, 32'hC000_0010});
        exp_q.push_back({2'd2, 32'hC000_0020});
        exp_q.push_back({2'd0, 32'hC000_0001});
        exp_q.push_back({2'd1, 32'hC000_0011});
        exp_q.push_back({2'd2, 32'hC000_0021});
        tx_ready = 1'b1;
        wait_drain("drain_rr");

        // Walk ch1 credits up to 250, then wrap the limit through zero.
        rst = 1'b1; tick(); rst = 1'b0;
        set_lim(1, 120);
        for (int k = 0; k < 8; k++) wr(1, 32'hD000_0000 + k, 15, 1'b1);
        wait_drain("drain_b1");
        chk("cc1_120", 64'(credit_consumed[15:8]), 64'd120);
        set_lim(1, 240);
        for (int k = 8; k < 16; k++) wr(1, 32'hD000_0000 + k, 15, 1'b1);
        wait_drain("drain_b2");
        set_lim(1, 250);
        wr(1, 32'hD000_0010, 10, 1'b1);
        wait_drain("drain_b3");
        chk("cc1_250", 64'(credit_consumed[15:8]), 64'd250);
        set_lim(1, 2);
        wr(1, 32'hD000_0011, 8, 1'b1);
        wait_drain("drain_wrap");
        chk("cc1_wrap", 64'(credit_consumed[15:8]), 64'd2);
        wr(1, 32'hD000_0012, 1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("wrap_block_ptlp1", 64'(ptlp[9:5]), 64'd1);
        chk("wrap_block_tx_valid", 64'(tx_valid), 64'd0);
        chk("wrap_block_cc1", 64'(credit_consumed[15:8]), 64'd2);

        // Reset while ch2 holds entries and the output stage is loaded.
        tx_ready = 1'b0;
        set_lim(2, 100);
        for (int k = 0; k < 4; k++) wr(2, 32'hE000_0000 + k, 1, 1'b0);
        tick();
        chk("pre_rst_tx_valid", 64'(tx_valid), 64'd1);
        chk("pre_rst_tx_ch", 64'(tx_ch), 64'd2);
        chk("pre_rst_ptlp2", 64'(ptlp[14:10]), 64'd3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("mid_rst_ptlp", 64'(ptlp), 64'd0);
        chk("mid_rst_cc", 64'(credit_consumed), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'h7);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
